// File: rtl/mmc3_scanline_irq_if.sv
// Bus bundle for the MMC3 scanline IRQ stage: CPU register writes, PPU A12 and the IRQ outputs.
interface mmc3_scanline_irq_if;
  logic        ce;
  logic        prg_write;
  logic [15:0] prg_ain;
  logic [7:0]  prg_din;
  logic        chr_a12;
  logic        irq_out;
  logic        a12_clk;
  logic [7:0]  counter_dbg;

  modport master (
    output ce, prg_write, prg_ain, prg_din, chr_a12,
    input  irq_out, a12_clk, counter_dbg
  );

  modport slave (
    input  ce, prg_write, prg_ain, prg_din, chr_a12,
    output irq_out, a12_clk, counter_dbg
  );
endinterface

// File: rtl/mmc3_scanline_irq.sv
// MMC3-class scanline IRQ: filters PPU A12 into scanline clocks, runs the reloadable
// 8-bit down-counter and decodes the $C000-$FFFF IRQ registers.
module mmc3_scanline_irq #(
  parameter int A12_LOW_CE   = 3,
  parameter int ALT_BEHAVIOR = 0
) (
  input  logic                clk,
  input  logic                reset,
  mmc3_scanline_irq_if.slave  bus
);

  localparam logic [3:0] LOW_MAX = 4'(A12_LOW_CE);

  logic [7:0] counter_q, counter_d;
  logic [7:0] latch_q, latch_d;
  logic       reload_q, reload_d;
  logic       en_q, en_d;
  logic       irq_q, irq_d;
  logic       a12_clk_q, a12_clk_d;
  logic       a12_prev_q, a12_prev_d;
  logic [3:0] low_cnt_q, low_cnt_d;

  logic       reg_wr_s;
  logic       rise_s;
  logic [7:0] step_s;
  logic       irq_hit_s;
  logic       unused_ain_s;

  assign unused_ain_s = ^bus.prg_ain[12:1];

  assign reg_wr_s  = bus.ce && bus.prg_write && bus.prg_ain[15] && bus.prg_ain[14];
  assign rise_s    = bus.ce && bus.chr_a12 && !a12_prev_q && (low_cnt_q == LOW_MAX);
  assign step_s    = ((counter_q == 8'd0) || reload_q) ? latch_q : (counter_q - 8'd1);
  // Old-style parts only fire when the counter actually moved onto zero.
  assign irq_hit_s = (step_s == 8'd0) && en_q &&
                     ((ALT_BEHAVIOR == 0) || (counter_q != 8'd0) || reload_q);

  // Next-state: filter and counter step first, then any register write overrides.
  always_comb begin
    counter_d  = counter_q;
    latch_d    = latch_q;
    reload_d   = reload_q;
    en_d       = en_q;
    irq_d      = irq_q;
    a12_clk_d  = 1'b0;
    a12_prev_d = a12_prev_q;
    low_cnt_d  = low_cnt_q;

    if (bus.ce) begin
      a12_prev_d = bus.chr_a12;
      if (bus.chr_a12) begin
        low_cnt_d = 4'd0;
      end else if (low_cnt_q != LOW_MAX) begin
        low_cnt_d = low_cnt_q + 4'd1;
      end else begin
        low_cnt_d = low_cnt_q;
      end

      if (rise_s) begin
        a12_clk_d = 1'b1;
        counter_d = step_s;
        reload_d  = 1'b0;
        if (irq_hit_s) begin
          irq_d = 1'b1;
        end else begin
          irq_d = irq_q;
        end
      end else begin
        a12_clk_d = 1'b0;
      end

      if (reg_wr_s) begin
        case ({bus.prg_ain[13], bus.prg_ain[0]})
          2'b00: latch_d = bus.prg_din;
          2'b01: begin
            counter_d = 8'd0;
            reload_d  = 1'b1;
          end
          2'b10: begin
            en_d  = 1'b0;
            irq_d = 1'b0;
          end
          2'b11: en_d = 1'b1;
          default: en_d = en_q;
        endcase
      end else begin
        en_d = en_d;
      end
    end else begin
      a12_clk_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q  <= 8'd0;
      latch_q    <= 8'd0;
      reload_q   <= 1'b0;
      en_q       <= 1'b0;
      irq_q      <= 1'b0;
      a12_clk_q  <= 1'b0;
      a12_prev_q <= 1'b0;
      low_cnt_q  <= 4'd0;
    end else begin
      counter_q  <= counter_d;
      latch_q    <= latch_d;
      reload_q   <= reload_d;
      en_q       <= en_d;
      irq_q      <= irq_d;
      a12_clk_q  <= a12_clk_d;
      a12_prev_q <= a12_prev_d;
      low_cnt_q  <= low_cnt_d;
    end
  end

  assign bus.irq_out     = irq_q;
  assign bus.a12_clk     = a12_clk_q;
  assign bus.counter_dbg = counter_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Bench for mmc3_scanline_irq: new (ALT=0) and old (ALT=1) variants run side by side
// against a reference model, with a directed vector table and corner-case sequences.
module tb_mmc3_scanline_irq;

  localparam int LOW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mmc3_scanline_irq_if bus_new ();
  mmc3_scanline_irq_if bus_old ();

  mmc3_scanline_irq #(.A12_LOW_CE(LOW), .ALT_BEHAVIOR(0)) dut_new (
    .clk(clk), .reset(reset), .bus(bus_new)
  );
  mmc3_scanline_irq #(.A12_LOW_CE(LOW), .ALT_BEHAVIOR(1)) dut_old (
    .clk(clk), .reset(reset), .bus(bus_old)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, index 0 = new behaviour, 1 = old behaviour.
  int m_cnt[2];
  int m_latch[2];
  bit m_reload[2];
  bit m_en[2];
  bit m_irq[2];
  bit m_clk;
  bit m_prev;
  int m_lowrun;

  logic        cur_ce, cur_wr, cur_a12;
  logic [15:0] cur_ain;
  logic [7:0]  cur_din;

  typedef struct packed {
    logic        ce;
    logic        wr;
    logic [15:0] ain;
    logic [7:0]  din;
    logic        a12;
    logic        e_clk;
    logic [7:0]  e_cnt;
    logic        e_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int v = 0; v < 2; v++) begin
      m_cnt[v] = 0; m_latch[v] = 0; m_reload[v] = 1'b0; m_en[v] = 1'b0; m_irq[v] = 1'b0;
    end
    m_clk = 1'b0; m_prev = 1'b0; m_lowrun = 0;
  endfunction

  function automatic void model_step();
    bit rise;
    int nxt;
    rise  = cur_ce && cur_a12 && !m_prev && (m_lowrun >= LOW);
    m_clk = rise;
    if (cur_ce) begin
      for (int v = 0; v < 2; v++) begin
        if (rise) begin
          nxt = (m_cnt[v] == 0 || m_reload[v]) ? m_latch[v] : m_cnt[v] - 1;
          if (nxt == 0 && m_en[v] && (v == 0 || m_cnt[v] != 0 || m_reload[v])) m_irq[v] = 1'b1;
          m_cnt[v]    = nxt;
          m_reload[v] = 1'b0;
        end
        if (cur_wr && cur_ain[15] && cur_ain[14]) begin
          if (!cur_ain[13] && !cur_ain[0]) m_latch[v] = int'(cur_din);
          if (!cur_ain[13] &&  cur_ain[0]) begin m_cnt[v] = 0; m_reload[v] = 1'b1; end
          if ( cur_ain[13] && !cur_ain[0]) begin m_en[v] = 1'b0; m_irq[v] = 1'b0; end
          if ( cur_ain[13] &&  cur_ain[0]) m_en[v] = 1'b1;
        end
      end
      m_prev   = cur_a12;
      m_lowrun = cur_a12 ? 0 : ((m_lowrun < 1000) ? m_lowrun + 1 : m_lowrun);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    check("mdl cnt new", bus_new.counter_dbg, m_cnt[0]);
    check("mdl irq new", bus_new.irq_out, m_irq[0]);
    check("mdl clk new", bus_new.a12_clk, m_clk);
    check("mdl cnt old", bus_old.counter_dbg, m_cnt[1]);
    check("mdl irq old", bus_old.irq_out, m_irq[1]);
    check("mdl clk old", bus_old.a12_clk, m_clk);
  endtask

  task automatic drive(input logic ce, input logic wr, input logic [15:0] ain,
                       input logic [7:0] din, input logic a12);
    cur_ce = ce; cur_wr = wr; cur_ain = ain; cur_din = din; cur_a12 = a12;
    bus_new.ce = ce; bus_new.prg_write = wr; bus_new.prg_ain = ain;
    bus_new.prg_din = din; bus_new.chr_a12 = a12;
    bus_old.ce = ce; bus_old.prg_write = wr; bus_old.prg_ain = ain;
    bus_old.prg_din = din; bus_old.chr_a12 = a12;
    tick();
  endtask

  task automatic expect_both(input string tag, input int e_clk, input int e_cnt,
                             input int e_irq_new, input int e_irq_old);
    check({tag, " clk new"}, bus_new.a12_clk, e_clk);
    check({tag, " cnt new"}, bus_new.counter_dbg, e_cnt);
    check({tag, " irq new"}, bus_new.irq_out, e_irq_new);
    check({tag, " clk old"}, bus_old.a12_clk, e_clk);
    check({tag, " cnt old"}, bus_old.counter_dbg, e_cnt);
    check({tag, " irq old"}, bus_old.irq_out, e_irq_old);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  task automatic wreg(input logic [15:0] ain, input logic [7:0] din);
    drive(1'b1, 1'b1, ain, din, 1'b0);
  endtask

  task automatic lows(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
  endtask

  task automatic rise();
    lows(4);
    drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
  endtask

  function automatic vec_t mk(input logic ce, input logic wr, input logic [15:0] ain,
                              input logic [7:0] din, input logic a12, input logic e_clk,
                              input logic [7:0] e_cnt, input logic e_irq);
    vec_t r;
    r.ce = ce; r.wr = wr; r.ain = ain; r.din = din; r.a12 = a12;
    r.e_clk = e_clk; r.e_cnt = e_cnt; r.e_irq = e_irq;
    return r;
  endfunction

  initial begin
    logic        a12_r;
    logic [15:0] a;

    // Count 2,1,0 with IRQ, acknowledge, then the short-glitch filter and a ce=0 hold.
    vecs.push_back(mk(1'b1, 1'b1, 16'hC000, 8'd2, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 16'hC001, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 16'hE001, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 8'd2, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 8'd1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 16'hE000, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b0, 8'd2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 16'hE001, 8'd0, 1'b0, 1'b0, 8'd2, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 16'h8001, 8'd9, 1'b0, 1'b0, 8'd2, 1'b0));

    do_reset();
    expect_both("reset", 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ce, vecs[i].wr, vecs[i].ain, vecs[i].din, vecs[i].a12);
      expect_both($sformatf("vec%0d", i), vecs[i].e_clk, vecs[i].e_cnt, vecs[i].e_irq, vecs[i].e_irq);
    end

    // Latch 0: new parts fire on every rise, old parts only on the first after $C001.
    do_reset();
    wreg(16'hC000, 8'd0); wreg(16'hC001, 8'd0); wreg(16'hE001, 8'd0);
    for (int i = 0; i < 3; i++) begin
      rise();
      expect_both($sformatf("latch0 rise%0d", i), 1, 0, 1, (i == 0) ? 1 : 0);
      wreg(16'hE000, 8'd0); wreg(16'hE001, 8'd0);
    end

    // $C001 coinciding with a rise: step 5->4 is overridden, next rise reloads 7.
    do_reset();
    wreg(16'hC000, 8'd5); wreg(16'hC001, 8'd0);
    rise();
    expect_both("c001 pre", 1, 5, 0, 0);
    wreg(16'hC000, 8'd7);
    lows(4);
    drive(1'b1, 1'b1, 16'hC001, 8'd0, 1'b1);
    expect_both("c001 coincide", 1, 0, 0, 0);
    rise();
    expect_both("c001 reload", 1, 7, 0, 0);

    // $E000 beats an IRQ-setting step; $E001 is too late for a coincident step.
    do_reset();
    wreg(16'hC000, 8'd1); wreg(16'hC001, 8'd0); wreg(16'hE001, 8'd0);
    rise();
    expect_both("e000 pre", 1, 1, 0, 0);
    lows(4);
    drive(1'b1, 1'b1, 16'hE000, 8'd0, 1'b1);
    expect_both("e000 coincide", 1, 0, 0, 0);
    wreg(16'hC000, 8'd0);
    lows(4);
    drive(1'b1, 1'b1, 16'hE001, 8'd0, 1'b1);
    expect_both("e001 coincide", 1, 0, 0, 0);
    rise();
    expect_both("e001 after", 1, 0, 1, 0);

    // Asynchronous reset while IRQ pending with counter 3.
    do_reset();
    wreg(16'hC000, 8'd0); wreg(16'hC001, 8'd0); wreg(16'hE001, 8'd0);
    rise();
    wreg(16'hC000, 8'd3);
    rise();
    expect_both("pre reset", 1, 3, 1, 1);
    #2 reset = 1'b1;
    #1;
    expect_both("async reset", 0, 0, 0, 0);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    expect_both("rise no low", 0, 0, 0, 0);

    // Randomized traffic against the model.
    do_reset();
    a12_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) a12_r = ~a12_r;
      a = 16'($urandom);
      if ($urandom_range(0, 5) != 0) a[15:14] = 2'b11;
      drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 7) == 0), a,
            8'($urandom_range(0, 3)), a12_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
